hsv_centroid: RTL and testbench

//  Consumes the registered h/s/v stream from the RGB->HSV converter, with pixel coordinates already

---
 rtl/hsv_centroid.sv | 224 ++++++++++++++++++++++
 tb/tb_hsv_centroid.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/hsv_centroid.sv
// HSV window classifier with per-frame blob accumulation and a sequential centroid divider.
// Pixels matching the window raise match one cycle later; the centroid is refreshed after each frame_end.
module hsv_centroid #(
    parameter int XW         = 11,
    parameter int YW         = 10,
    parameter int CNT_W      = 20,
    parameter int MIN_PIXELS = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [7:0]        h,
    input  logic [7:0]        s,
    input  logic [7:0]        v,
    input  logic              pix_valid,
    input  logic [XW-1:0]     x,
    input  logic [YW-1:0]     y,
    input  logic              frame_end,
    input  logic [7:0]        h_lo,
    input  logic [7:0]        h_hi,
    input  logic [7:0]        s_min,
    input  logic [7:0]        v_min,
    output logic              match,
    output logic [XW-1:0]     centroid_x,
    output logic [YW-1:0]     centroid_y,
    output logic              found,
    output logic              done,
    output logic              busy,
    output logic              overrun
);

    localparam int N   = (XW > YW) ? XW : YW;
    localparam int IW  = $clog2(N + 1);
    localparam int SXW = XW + CNT_W;
    localparam int SYW = YW + CNT_W;

    localparam logic [IW-1:0]    LAST_IT = IW'(N);
    localparam logic [IW-1:0]    X_IT    = IW'(XW);
    localparam logic [IW-1:0]    Y_IT    = IW'(YW);
    localparam logic [CNT_W-1:0] MIN_C   = CNT_W'(MIN_PIXELS);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        DIVIDE = 1'b1
    } state_t;

    state_t             state_r;
    logic [IW-1:0]      iter_r;

    // live accumulators for the frame currently arriving
    logic [CNT_W-1:0]   count_r;
    logic [SXW-1:0]     sum_x_r;
    logic [SYW-1:0]     sum_y_r;

    // divider working registers
    logic [CNT_W-1:0]   snap_count_r;
    logic [CNT_W-1:0]   rem_x_r;
    logic [CNT_W-1:0]   rem_y_r;
    logic [XW-1:0]      low_x_r;
    logic [YW-1:0]      low_y_r;
    logic [XW-1:0]      q_x_r;
    logic [YW-1:0]      q_y_r;

    logic               hue_ok_s;
    logic               hit_s;
    logic               add_s;
    logic [CNT_W-1:0]   count_next_s;
    logic [SXW-1:0]     sum_x_next_s;
    logic [SYW-1:0]     sum_y_next_s;

    logic [CNT_W:0]     div_s;
    logic [CNT_W:0]     trial_x_s;
    logic [CNT_W:0]     trial_y_s;
    logic               ge_x_s;
    logic               ge_y_s;
    logic [CNT_W-1:0]   rem_x_step_s;
    logic [CNT_W-1:0]   rem_y_step_s;

    // Window test; a reversed hue window wraps through 0
    always_comb begin
        hue_ok_s = 1'b0;
        if (h_lo <= h_hi) begin
            hue_ok_s = (h >= h_lo) && (h <= h_hi);
        end else begin
            hue_ok_s = (h >= h_lo) || (h <= h_hi);
        end
        hit_s = pix_valid && hue_ok_s && (s >= s_min) && (v >= v_min);
    end

    // Next accumulator values; a saturated counter drops further pixels entirely
    always_comb begin
        add_s        = hit_s && !(&count_r);
        count_next_s = count_r;
        sum_x_next_s = sum_x_r;
        sum_y_next_s = sum_y_r;
        if (add_s) begin
            count_next_s = count_r + {{(CNT_W-1){1'b0}}, 1'b1};
            sum_x_next_s = sum_x_r + {{CNT_W{1'b0}}, x};
            sum_y_next_s = sum_y_r + {{CNT_W{1'b0}}, y};
        end else begin
            count_next_s = count_r;
            sum_x_next_s = sum_x_r;
            sum_y_next_s = sum_y_r;
        end
    end

    // One restoring-division step for each axis, remainder kept below the divisor
    always_comb begin
        div_s     = {1'b0, snap_count_r};
        trial_x_s = {rem_x_r, low_x_r[XW-1]};
        trial_y_s = {rem_y_r, low_y_r[YW-1]};
        ge_x_s    = (trial_x_s >= div_s);
        ge_y_s    = (trial_y_s >= div_s);
        if (ge_x_s) begin
            rem_x_step_s = trial_x_s[CNT_W-1:0] - snap_count_r;
        end else begin
            rem_x_step_s = trial_x_s[CNT_W-1:0];
        end
        if (ge_y_s) begin
            rem_y_step_s = trial_y_s[CNT_W-1:0] - snap_count_r;
        end else begin
            rem_y_step_s = trial_y_s[CNT_W-1:0];
        end
    end

    // Match mask and live accumulators; frame_end always starts a fresh frame
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            match   <= 1'b0;
            count_r <= '0;
            sum_x_r <= '0;
            sum_y_r <= '0;
        end else begin
            match <= hit_s;
            if (frame_end) begin
                count_r <= '0;
                sum_x_r <= '0;
                sum_y_r <= '0;
            end else begin
                count_r <= count_next_s;
                sum_x_r <= sum_x_next_s;
                sum_y_r <= sum_y_next_s;
            end
        end
    end

    // Control FSM and divider datapath with registered result outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            iter_r       <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            overrun      <= 1'b0;
            found        <= 1'b0;
            centroid_x   <= '0;
            centroid_y   <= '0;
            snap_count_r <= '0;
            rem_x_r      <= '0;
            rem_y_r      <= '0;
            low_x_r      <= '0;
            low_y_r      <= '0;
            q_x_r        <= '0;
            q_y_r        <= '0;
        end else begin
            done    <= 1'b0;
            overrun <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (frame_end) begin
                        // snapshot includes a hit arriving in the frame_end cycle
                        snap_count_r <= count_next_s;
                        rem_x_r      <= sum_x_next_s[SXW-1:XW];
                        low_x_r      <= sum_x_next_s[XW-1:0];
                        rem_y_r      <= sum_y_next_s[SYW-1:YW];
                        low_y_r      <= sum_y_next_s[YW-1:0];
                        q_x_r        <= '0;
                        q_y_r        <= '0;
                        iter_r       <= '0;
                        busy         <= 1'b1;
                        state_r      <= DIVIDE;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                DIVIDE: begin
                    if (frame_end) begin
                        overrun <= 1'b1;
                    end else begin
                        overrun <= 1'b0;
                    end
                    if (iter_r == LAST_IT) begin
                        state_r <= IDLE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        if (snap_count_r >= MIN_C) begin
                            centroid_x <= q_x_r;
                            centroid_y <= q_y_r;
                            found      <= 1'b1;
                        end else begin
                            found <= 1'b0;
                        end
                    end else begin
                        iter_r <= iter_r + {{(IW-1){1'b0}}, 1'b1};
                        if ((iter_r < X_IT) && (snap_count_r != '0)) begin
                            rem_x_r <= rem_x_step_s;
                            low_x_r <= {low_x_r[XW-2:0], 1'b0};
                            q_x_r   <= {q_x_r[XW-2:0], ge_x_s};
                        end
                        if ((iter_r < Y_IT) && (snap_count_r != '0)) begin
                            rem_y_r <= rem_y_step_s;
                            low_y_r <= {low_y_r[YW-2:0], 1'b0};
                            q_y_r   <= {q_y_r[YW-2:0], ge_y_s};
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hsv_centroid.sv
// Directed bench for hsv_centroid: three instances share one stimulus stream so that
// different MIN_PIXELS / CNT_W settings can be compared against hand-computed results.
module tb_hsv_centroid;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  h, s, v, h_lo, h_hi, s_min, v_min;
    logic        pix_valid, frame_end;
    logic [10:0] x;
    logic [9:0]  y;

    logic        m_a, f_a, d_a, b_a, o_a;
    logic [10:0] cx_a;
    logic [9:0]  cy_a;
    logic        m_b, f_b, d_b, b_b, o_b;
    logic [10:0] cx_b;
    logic [9:0]  cy_b;
    logic        m_c, f_c, d_c, b_c, o_c;
    logic [10:0] cx_c;
    logic [9:0]  cy_c;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    hsv_centroid #(.XW(11), .YW(10), .CNT_W(20), .MIN_PIXELS(4)) u_a (
        .clock(clock), .reset(reset), .h(h), .s(s), .v(v), .pix_valid(pix_valid),
        .x(x), .y(y), .frame_end(frame_end), .h_lo(h_lo), .h_hi(h_hi),
        .s_min(s_min), .v_min(v_min), .match(m_a), .centroid_x(cx_a), .centroid_y(cy_a),
        .found(f_a), .done(d_a), .busy(b_a), .overrun(o_a));

    hsv_centroid #(.XW(11), .YW(10), .CNT_W(20), .MIN_PIXELS(2)) u_b (
        .clock(clock), .reset(reset), .h(h), .s(s), .v(v), .pix_valid(pix_valid),
        .x(x), .y(y), .frame_end(frame_end), .h_lo(h_lo), .h_hi(h_hi),
        .s_min(s_min), .v_min(v_min), .match(m_b), .centroid_x(cx_b), .centroid_y(cy_b),
        .found(f_b), .done(d_b), .busy(b_b), .overrun(o_b));

    hsv_centroid #(.XW(11), .YW(10), .CNT_W(4), .MIN_PIXELS(3)) u_c (
        .clock(clock), .reset(reset), .h(h), .s(s), .v(v), .pix_valid(pix_valid),
        .x(x), .y(y), .frame_end(frame_end), .h_lo(h_lo), .h_hi(h_hi),
        .s_min(s_min), .v_min(v_min), .match(m_c), .centroid_x(cx_c), .centroid_y(cy_c),
        .found(f_c), .done(d_c), .busy(b_c), .overrun(o_c));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic pix(input logic pv, input logic [7:0] hh, input logic [7:0] ss,
                       input logic [10:0] xx, input logic [9:0] yy, input logic fe);
        pix_valid = pv; h = hh; s = ss; v = 8'd100; x = xx; y = yy; frame_end = fe;
        step();
        pix_valid = 1'b0; frame_end = 1'b0;
    endtask

    task automatic hit(input logic [10:0] xx, input logic [9:0] yy);
        pix(1'b1, 8'd50, 8'd100, xx, yy, 1'b0);
    endtask

    task automatic end_frame();
        pix(1'b0, 8'd0, 8'd0, 11'd0, 10'd0, 1'b1);
    endtask

    task automatic wait_done();
        int cyc;
        cyc = 0;
        while (d_a !== 1'b1 && cyc < 40) begin
            step();
            cyc++;
        end
        check("done_timeout", {31'd0, d_a}, 32'd1);
    endtask

    initial begin
        int seen;
        reset = 1'b1; pix_valid = 1'b0; frame_end = 1'b0;
        h = 8'd0; s = 8'd0; v = 8'd0; x = 11'd0; y = 10'd0;
        h_lo = 8'd240; h_hi = 8'd10; s_min = 8'd0; v_min = 8'd0;
        step(); step();
        check("reset_outputs", {14'd0, m_a, cx_a, cy_a, f_a, d_a, b_a, o_a}, 32'd0);
        reset = 1'b0;
        step();

        // hue wrap window
        pix(1'b1, 8'd250, 8'd0, 11'd0, 10'd0, 1'b0); check("wrap_h250", {31'd0, m_a}, 32'd1);
        pix(1'b1, 8'd5,   8'd0, 11'd0, 10'd0, 1'b0); check("wrap_h5",   {31'd0, m_a}, 32'd1);
        pix(1'b1, 8'd128, 8'd0, 11'd0, 10'd0, 1'b0); check("wrap_h128", {31'd0, m_a}, 32'd0);

        // plain window, inclusive bounds, saturation floor, pix_valid gating
        h_lo = 8'd10; h_hi = 8'd100; s_min = 8'd50; v_min = 8'd50;
        pix(1'b1, 8'd5,   8'd100, 11'd0, 10'd0, 1'b0); check("hue_below", {31'd0, m_a}, 32'd0);
        pix(1'b1, 8'd100, 8'd100, 11'd0, 10'd0, 1'b0); check("hue_edge",  {31'd0, m_a}, 32'd1);
        pix(1'b1, 8'd50,  8'd49,  11'd0, 10'd0, 1'b0); check("sat_low",   {31'd0, m_a}, 32'd0);
        pix(1'b0, 8'd50,  8'd100, 11'd0, 10'd0, 1'b0); check("not_valid", {31'd0, m_a}, 32'd0);

        reset = 1'b1; step(); reset = 1'b0; step();

        // centroid of a 2x2 square, with exact done latency
        hit(11'd10, 10'd20); hit(11'd12, 10'd20); hit(11'd10, 10'd22); hit(11'd12, 10'd22);
        end_frame();
        check("busy_start", {31'd0, b_a}, 32'd1);
        for (int i = 0; i < 10; i++) step();
        step(); check("done_early", {31'd0, d_a}, 32'd0);
        step(); check("done_at_12", {31'd0, d_a}, 32'd1);
        check("cen_x", {21'd0, cx_a}, 32'd11);
        check("cen_y", {22'd0, cy_a}, 32'd21);
        check("cen_found", {31'd0, f_a}, 32'd1);
        step(); check("done_pulse", {30'd0, d_a, b_a}, 32'd0);

        // truncation and threshold: two hits plus one rejected pixel
        hit(11'd0, 10'd0); hit(11'd1, 10'd1);
        pix(1'b1, 8'd50, 8'd20, 11'd500, 10'd500, 1'b0);
        end_frame();
        wait_done();
        check("trunc_b", {10'd0, cx_b, cy_b}, 32'd0);
        check("trunc_b_found", {31'd0, f_b}, 32'd1);
        check("thresh_c_found", {31'd0, f_c}, 32'd0);
        check("thresh_c_hold", {10'd0, cx_c, cy_c}, {10'd0, 11'd11, 10'd21});
        check("thresh_a_found", {31'd0, f_a}, 32'd0);
        step();

        // overlap: hit on frame_end cycle, discarded frame, hits during DIVIDE
        hit(11'd100, 10'd40); hit(11'd102, 10'd40); hit(11'd100, 10'd42);
        pix(1'b1, 8'd50, 8'd100, 11'd102, 10'd42, 1'b1);
        step();
        hit(11'd200, 10'd100);
        step(); step();
        end_frame();
        check("overrun_pulse", {31'd0, o_a}, 32'd1);
        hit(11'd300, 10'd200);
        check("overrun_clear", {31'd0, o_a}, 32'd0);
        hit(11'd300, 10'd200); hit(11'd300, 10'd200); hit(11'd300, 10'd200);
        wait_done();
        check("ovl_first", {10'd0, cx_a, cy_a}, {10'd0, 11'd101, 10'd41});
        check("ovl_first_found", {31'd0, f_a}, 32'd1);
        step();
        end_frame();
        wait_done();
        check("ovl_next", {10'd0, cx_a, cy_a}, {10'd0, 11'd300, 10'd200});
        step();

        // reset during DIVIDE iteration 4
        hit(11'd50, 10'd60); hit(11'd50, 10'd60); hit(11'd50, 10'd60); hit(11'd50, 10'd60);
        end_frame();
        step(); step(); step(); step();
        reset = 1'b1;
        #1;
        check("rst_mid_div", {14'd0, m_a, cx_a, cy_a, f_a, d_a, b_a, o_a}, 32'd0);
        step(); step();
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (d_a === 1'b1) seen++;
        end
        check("rst_no_done", seen, 32'd0);
        hit(11'd7, 10'd9); hit(11'd7, 10'd9); hit(11'd7, 10'd9); hit(11'd7, 10'd9);
        end_frame();
        wait_done();
        check("post_rst", {9'd0, f_a, cx_a, cy_a}, {9'd0, 1'b1, 11'd7, 10'd9});
        step();

        // counter saturation on the CNT_W=4 instance
        for (int i = 0; i < 20; i++) hit(11'd3, 10'd5);
        end_frame();
        wait_done();
        check("sat_c", {9'd0, f_c, cx_c, cy_c}, {9'd0, 1'b1, 11'd3, 10'd5});
        check("sat_a", {9'd0, f_a, cx_a, cy_a}, {9'd0, 1'b1, 11'd3, 10'd5});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
